demux2_reg: RTL
===============

Name: demux2_reg

Overview:
- Registered 1-to-2 demultiplexer. It routes a width-bit source word to one of two destination ports, or to both ports in broadcast mode.
- It is the distribution-side counterpart of the 2:1 operand select on the processor datapath. It sits between the ALU/bus result and the two destination register-file/bus write ports.
- Each destination has a one-entry output register with a valid/ready handshake, so slow consumers back-pressure the source.
- Per-destination delivery counters support debug.

Parameters:
- width, 16, data word width of the input and of both outputs.
- cnt_width, 8, width of each delivery counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  width  source word.
- sel_one  input  1  destination select: 0 -> port one, 1 -> port two. Ignored when sel_two=1.
- sel_two  input  1  broadcast: 1 -> write the word to both ports.
- in_valid  input  1  source presents a word.
- in_ready  output  1  block accepts the word this cycle.
- data_one  output  width  port-one registered word.
- valid_one  output  1  port-one word valid.
- ready_one  input  1  port-one consumer accepts.
- data_two  output  width  port-two registered word.
- valid_two  output  1  port-two word valid.
- ready_two  input  1  port-two consumer accepts.
- cnt_one  output  cnt_width  words delivered on port one.
- cnt_two  output  cnt_width  words delivered on port two.

Behaviour:
- Reset (async assert, any cycle): valid_one=valid_two=0, data_one=data_two=0, cnt_one=cnt_two=0. Words pending in the slots are discarded. Release is synchronous to clk.
- Slot k can accept when: open_k = !valid_k || ready_k. Draining and loading may happen in the same cycle.
- in_ready is combinational:
  - sel_two=1: open_one && open_two.
  - sel_two=0, sel_one=0: open_one.
  - sel_two=0, sel_one=1: open_two.
- in_ready does not depend on in_valid.
- Input transfer occurs when in_valid && in_ready. On the next edge each selected slot loads data_in and sets valid_k=1. Input-to-output latency is 1 cycle.
- Output transfer on slot k occurs when valid_k && ready_k:
  - If slot k is not loaded the same cycle, valid_k clears.
  - If slot k is loaded the same cycle, valid_k stays 1 with the new data (back-to-back, full throughput, no bubble).
- Stall: while valid_k && !ready_k, data_k and valid_k hold stable. The other slot continues independently.
- Broadcast is all-or-nothing. If either slot is blocked, neither slot loads and in_ready=0.
- sel_one/sel_two are sampled only on an accepted cycle. Changes while in_ready=0 have no effect.
- Counters: cnt_k increments by 1 on each output transfer on port k. It wraps from 2^cnt_width-1 to 0 and never saturates.
- No internal FSM beyond the two slot states (EMPTY, FULL). Transitions:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load, or on stall.

Decomposition:
- Shared package holds:
  - Select encodings: SEL_ONE=1'b0, SEL_TWO=1'b1, BCAST=1'b1 on sel_two.
  - Default width (16) and default cnt_width (8).
- One sub-module is natural: demux_slot. It is a one-entry valid/ready register with its delivery counter, parameterised by width and cnt_width. It exposes open, a load strobe, data, valid, ready and count, and is instantiated twice.
- Top level holds the select decode and in_ready logic.

Test Plan:
- Reset, then single route: rst pulse; data_in=16'hA5A5, sel_one=0, sel_two=0, in_valid=1 for one cycle, ready_one=1 -> next cycle data_one=A5A5, valid_one=1, valid_two=0; the cycle after, valid_one=0 and cnt_one=1.
- Back-pressure: ready_two=0; send 16'h1234 to port two, then present 16'h5678 to port two -> in_ready=0, data_two holds 1234. Raise ready_two -> 5678 is loaded the next edge with no bubble; cnt_two increments.
- Broadcast blocked: valid_one=1 stalled (ready_one=0), sel_two=1, data_in=16'h00FF -> in_ready=0, port two unchanged. Release ready_one -> both ports show 00FF on the same cycle.
- Throughput: stream 20 words alternating sel_one with ready_one=ready_two=1 -> in_ready=1 every cycle, each word appears on the correct port one cycle later, cnt_one=cnt_two=10.
- Counter wrap and reset mid-operation: deliver 257 words on port one -> cnt_one=1. With valid_two=1 pending, assert rst asynchronously mid-cycle -> valid_two=0, data_two=0 and counters=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/demux2_reg_pkg.sv
// demux2_reg_pkg
//   Shared definitions for the registered 1-to-2 demultiplexer:
//   select encodings, slot state encodings, default widths and the
//   select-to-destination decode used by the top level.
package demux2_reg_pkg;

  // Select encodings: sel_one picks the single destination, sel_two = BCAST
  // overrides it and writes both ports.
  localparam logic SEL_ONE = 1'b0;
  localparam logic SEL_TWO = 1'b1;
  localparam logic BCAST   = 1'b1;

  // One-entry slot states.
  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_FULL  = 1'b1;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_CNT_WIDTH = 8;

  // Destination mask: bit 0 = port one, bit 1 = port two.
  function automatic logic [1:0] route_mask(input logic sel_one, input logic sel_two);
    if (sel_two == BCAST) begin
      return 2'b11;
    end else if (sel_one == SEL_TWO) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/demux2_reg_slot.sv
// demux_slot
//   One-entry valid/ready output register with a delivery counter.
//   Ports:
//     clk, rst      clock, async active-high reset
//     load          strobe: capture load_data on this edge (caller guarantees open)
//     load_data     word to capture
//     open          slot can take a word this cycle (empty or draining)
//     data, valid   registered word and its valid flag
//     ready         consumer accepts the word
//     count         number of words delivered (wraps)
//
//   state      | meaning
//   SLOT_EMPTY | no word held, valid=0
//   SLOT_FULL  | word held, valid=1, waiting for ready
module demux_slot
  import demux2_reg_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int cnt_width = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [width-1:0]     load_data,
  output logic                 open,
  output logic [width-1:0]     data,
  output logic                 valid,
  input  logic                 ready,
  output logic [cnt_width-1:0] count
);

  localparam logic [cnt_width-1:0] CNT_INC = {{(cnt_width-1){1'b0}}, 1'b1};

  logic                 state_q, state_d;
  logic [width-1:0]     data_q, data_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (state_q == SLOT_FULL && ready) begin
      state_d = SLOT_EMPTY;
      cnt_d   = cnt_q + CNT_INC;
    end
    // A load in the same cycle as a drain keeps the slot full: no bubble.
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign open  = (state_q == SLOT_EMPTY) || ready;
  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;
  assign count = cnt_q;

endmodule

// File: rtl/demux2_reg.sv
// demux2_reg
//   Registered 1-to-2 demultiplexer between the result bus and two
//   destination write ports, with broadcast and per-port delivery counters.
//   Ports:
//     clk, rst                  clock, async active-high reset
//     data_in, in_valid         source word and its valid
//     sel_one, sel_two          destination select / broadcast
//     in_ready                  word accepted this cycle (combinational)
//     data_*, valid_*, ready_*  per-destination output handshake
//     cnt_one, cnt_two          per-destination delivery counters
module demux2_reg
  import demux2_reg_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int cnt_width = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     data_in,
  input  logic                 sel_one,
  input  logic                 sel_two,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [width-1:0]     data_one,
  output logic                 valid_one,
  input  logic                 ready_one,
  output logic [width-1:0]     data_two,
  output logic                 valid_two,
  input  logic                 ready_two,
  output logic [cnt_width-1:0] cnt_one,
  output logic [cnt_width-1:0] cnt_two
);

  logic [1:0] dest;
  logic       open_one, open_two;
  logic       accept;
  logic       load_one, load_two;

  assign dest = route_mask(sel_one, sel_two);

  // Every selected slot must be open; broadcast is all-or-nothing.
  assign in_ready = (!dest[0] || open_one) && (!dest[1] || open_two);
  assign accept   = in_valid && in_ready;
  assign load_one = accept && dest[0];
  assign load_two = accept && dest[1];

  demux_slot #(.width(width), .cnt_width(cnt_width)) u_slot_one (
    .clk       (clk),
    .rst       (rst),
    .load      (load_one),
    .load_data (data_in),
    .open      (open_one),
    .data      (data_one),
    .valid     (valid_one),
    .ready     (ready_one),
    .count     (cnt_one)
  );

  demux_slot #(.width(width), .cnt_width(cnt_width)) u_slot_two (
    .clk       (clk),
    .rst       (rst),
    .load      (load_two),
    .load_data (data_in),
    .open      (open_two),
    .data      (data_two),
    .valid     (valid_two),
    .ready     (ready_two),
    .count     (cnt_two)
  );

endmodule
